branch_redirect_ctrl: RTL

Sequences the pipeline redirect after a branch or jump resolves in EX. The fetch side is static predict-not-taken.
- Takes the EX-stage branch decision (Branch, taken, jump, target).
- Issues a registered PC redirect to fetch with a valid/ready handshake; fetch may be blocked by an I-cache miss.
- Squashes wrong-path instructions in IF/ID and ID/EX until the new path enters the pipe.
- Keeps saturating branch/taken statistics counters.

---
 rtl/branch_redirect_ctrl_pkg.sv | 32 +++
 rtl/branch_redirect_ctrl_sat_counter.sv | 21 ++
 rtl/branch_redirect_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: FSM state
// encodings, the squash counter width, common branch FUNCT3 codes and the
// redirect decision helper.
package branch_redirect_ctrl_pkg;

    // Redirect sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDIR  = 2'd1,
        ST_SQUASH = 2'd2
    } redir_state_e;

    // Squash counter holds values 1..7
    localparam int SQ_CNT_W = 3;

    // Conditional branch FUNCT3 codes (RV32I)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // A jump always redirects; a conditional branch only when taken
    // (fetch predicts not-taken).
    function automatic logic needs_redirect(input logic jump,
                                            input logic branch,
                                            input logic taken);
        return jump | (branch & taken);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Width-parameterised saturating incrementer with enable. Sticks at
// all-ones instead of wrapping.
module branch_redirect_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // Increment on enable unless already at the all-ones ceiling
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer for branches/jumps resolved in EX. Fetch predicts
// not-taken, so every taken branch or jump sends a registered redirect to
// fetch, flushes the wrong-path instructions in IF/ID and ID/EX, then holds
// the IF/ID flush for SQUASH_CYC cycles until the new path enters the pipe.
//
// Redirect handshake: redir_valid/redir_pc form a valid/ready channel.
// Once redir_valid rises, redir_valid and redir_pc stay unchanged until the
// rising edge where redir_valid & fetch_ready are both 1; that edge is the
// transfer. redir_valid never drops without a transfer (except by reset).
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SQUASH_CYC = 1,
    parameter int STAT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic              ex_branch,
    input  logic              ex_jump,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              fetch_ready,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_pc,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              busy,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] taken_cnt,
    output redir_state_e      dbg_state
);

    localparam logic [SQ_CNT_W-1:0] SQ_LOAD = SQ_CNT_W'(SQUASH_CYC);

    redir_state_e        state;
    logic [SQ_CNT_W-1:0] sq_cnt;
    logic                ex_fire;
    logic                redirect_req;
    logic                branch_en;
    logic                taken_en;

    // A stalled EX instruction repeats; act only on the cycle it moves on
    always_comb begin
        ex_fire      = ex_valid & ~ex_stall;
        redirect_req = ex_fire & needs_redirect(ex_jump, ex_branch, ex_taken);
        // Statistics only on the correct path (IDLE); jumps never count
        branch_en    = (state == ST_IDLE) & ex_fire & ex_branch & ~ex_jump;
        taken_en     = branch_en & ex_taken;
    end

    assign dbg_state = state;

    // Redirect sequencer with registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            sq_cnt      <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            flush_ifid  <= 1'b0;
            flush_idex  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect_req) begin
                        state       <= ST_REDIR;
                        redir_pc    <= ex_target;
                        redir_valid <= 1'b1;
                        flush_ifid  <= 1'b1;
                        flush_idex  <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ST_REDIR: begin
                    // EX holds wrong-path work here; only fetch_ready matters
                    if (fetch_ready) begin
                        state       <= ST_SQUASH;
                        sq_cnt      <= SQ_LOAD;
                        redir_valid <= 1'b0;
                        flush_idex  <= 1'b0;
                    end
                end
                ST_SQUASH: begin
                    sq_cnt <= sq_cnt - 1'b1;
                    if (sq_cnt == SQ_CNT_W'(1)) begin
                        state      <= ST_IDLE;
                        flush_ifid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    redir_valid <= 1'b0;
                    flush_ifid  <= 1'b0;
                    flush_idex  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    branch_redirect_ctrl_sat_counter #(.W(STAT_W)) u_branch_cnt (
        .clock (clock),
        .reset (reset),
        .en    (branch_en),
        .count (branch_cnt)
    );

    branch_redirect_ctrl_sat_counter #(.W(STAT_W)) u_taken_cnt (
        .clock (clock),
        .reset (reset),
        .en    (taken_en),
        .count (taken_cnt)
    );

endmodule
